inpdt_seq_ctrl: RTL and testbench
=================================

Name: inpdt_seq_ctrl

Overview:
Sequencer for the 16-lane 8b inner-product datapath (inpdt_16). It computes one long dot product, such as an LSTM gate pre-activation, over N 16-element chunks.
- Issues chunk addresses to the X/W operand buffers, which are synchronous with 1-cycle read latency.
- Gates the datapath enable and accumulates its 21-bit partial results into a wide accumulator.
- Returns the final sum through a valid/ready output handshake.

Parameters:
MAX_CHUNKS, 16, maximum chunks per job (power of 2)
ADDR_W, 4, buffer address width, log2(MAX_CHUNKS)
ACC_W, 25, accumulator width, 21 + ADDR_W; guarantees no overflow

Ports:
iClk  input  1  clock, rising edge
iRstn  input  1  reset, asynchronous, active-low
iStart  input  1  job request, sampled in IDLE only
iNumChunk  input  ADDR_W+1  chunk count N for the job, valid range 1..MAX_CHUNKS
iAbort  input  1  synchronous abort
iInpdtResult  input  21  oResult from inpdt_16 (combinational from buffer data)
iReady  input  1  downstream accepts result
oAddr  output  ADDR_W  X/W buffer read address
oRdEn  output  1  buffer read strobe
oInpdtEn  output  1  iEn to inpdt_16; high in data-phase cycles only
oBusy  output  1  job in progress (state != IDLE)
oAcc  output  ACC_W  accumulated result
oValid  output  1  oAcc is final
oErr  output  1  1-cycle pulse on rejected start

Behaviour:
- Reset (iRstn=0, async): state=IDLE. oAddr, oRdEn, oInpdtEn, oBusy, oAcc, oValid, oErr all 0. Chunk counter and latched N are 0.
- States: IDLE, RUN, LAST, DONE.
- IDLE:
  - iStart=1 with 1<=iNumChunk<=MAX_CHUNKS: latch N, clear oAcc to 0, counter=0, go to RUN.
  - iStart=1 with iNumChunk out of range: oErr=1 for one cycle, stay IDLE.
- RUN:
  - Each cycle: oRdEn=1, oAddr=counter, counter increments.
  - When the issued address equals N-1, go to LAST next cycle.
- Data phase: oInpdtEn is the registered oRdEn, i.e. high exactly one cycle after each read issue.
  - On each edge where oInpdtEn=1: oAcc <= oAcc + zero-extended iInpdtResult (unsigned).
- LAST:
  - oRdEn=0, oInpdtEn=1 for the final chunk, final accumulate.
  - Next state DONE.
- DONE:
  - oValid=1; oAcc stable.
  - On iValid&iReady edge (oValid=1 and iReady=1): go to IDLE, oValid=0. oAcc keeps its value until the next accepted start.
- Latency: start accepted at edge 0 → addresses 0..N-1 on cycles 1..N → oInpdtEn on cycles 2..N+1 → oValid rises at edge N+2. Job throughput is 1 chunk/cycle.
- iStart while oBusy=1: ignored, no oErr.
- iAbort=1 in any non-IDLE state:
  - Next edge: IDLE, oAcc=0.
  - oRdEn, oInpdtEn, oValid deasserted; the pending data-phase accumulate is discarded.
  - iAbort has priority over all transitions. iAbort in IDLE has no effect, and iStart is ignored in the same cycle.
- In DONE with iReady held high: exactly one transfer, then IDLE. Back-to-back start is accepted from the IDLE cycle onward.
- Overflow: impossible by construction. Max value is MAX_CHUNKS*16*255*255 = 16,646,400 < 2^25. No saturation logic.
- Reset asserted mid-job: immediate return to reset values. No result is produced.

Test Plan:
- N=1, all X=W=1 (iInpdtResult=16): start at edge 0 → oAddr=0 at cycle 1, oInpdtEn at cycle 2, oValid at edge 3 with oAcc=16, oBusy low after iReady.
- N=4, results 100/200/300/400 per chunk: oAcc=1000, oValid at edge 6; oAddr sequence 0,1,2,3 with no gaps.
- N=16, all operands 255 (result 1,040,400 each): oAcc=16,646,400 exactly, no wrap.
- Backpressure: iReady low for 5 cycles in DONE → oValid and oAcc stay constant, iStart pulses ignored. iReady high → IDLE next cycle. A new start then accumulates from 0.
- Invalid start: iNumChunk=0, then 17 → oErr pulses 1 cycle each, oBusy stays 0, no oRdEn.
- Abort at cycle 3 of an N=8 job → IDLE next edge, oAcc=0, oValid never asserted. The same with iRstn pulled low mid-job → all outputs 0 asynchronously.

Source files
------------

// File: rtl/inpdt_seq_ctrl.sv
// Chunk sequencer for the inpdt_16 inner-product datapath: issues buffer
// reads, accumulates the 21-bit partial sums and hands back the total.
module inpdt_seq_ctrl #(
    parameter int MAX_CHUNKS = 16,
    parameter int ADDR_W     = 4,
    parameter int ACC_W      = 25
) (
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iStart,
    input  logic [ADDR_W:0]   iNumChunk,
    input  logic              iAbort,
    input  logic [20:0]       iInpdtResult,
    input  logic              iReady,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oRdEn,
    output logic              oInpdtEn,
    output logic              oBusy,
    output logic [ACC_W-1:0]  oAcc,
    output logic              oValid,
    output logic              oErr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAST,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] MaxN = (ADDR_W + 1)'(MAX_CHUNKS);
    localparam logic [ADDR_W:0] One  = (ADDR_W + 1)'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q;
    logic                en_q;
    logic [ACC_W-1:0]    acc_q;
    logic                valid_q;
    logic                err_q;

    logic start_ok;
    logic last_issue;

    assign start_ok   = (iNumChunk != '0) && (iNumChunk <= MaxN);
    assign last_issue = ({1'b0, cnt_q} == (num_q - One));

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            en_q    <= 1'b0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (iAbort && state_q != IDLE) begin
                // Drop everything in flight, including the pending accumulate.
                state_q <= IDLE;
                cnt_q   <= '0;
                addr_q  <= '0;
                rd_q    <= 1'b0;
                en_q    <= 1'b0;
                acc_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                en_q <= rd_q;
                if (en_q) begin
                    acc_q <= acc_q + ACC_W'(iInpdtResult);
                end
                unique case (state_q)
                    IDLE: begin
                        if (iStart && !iAbort) begin
                            if (start_ok) begin
                                num_q   <= iNumChunk;
                                acc_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= RUN;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        rd_q   <= 1'b1;
                        addr_q <= cnt_q;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_issue) begin
                            state_q <= LAST;
                        end
                    end
                    LAST: begin
                        rd_q    <= 1'b0;
                        state_q <= DONE;
                    end
                    DONE: begin
                        // The final accumulate lands on the edge that raises valid.
                        if (valid_q && iReady) begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign oAddr    = addr_q;
    assign oRdEn    = rd_q;
    assign oInpdtEn = en_q;
    assign oBusy    = (state_q != IDLE);
    assign oAcc     = acc_q;
    assign oValid   = valid_q;
    assign oErr     = err_q;

endmodule

// File: tb/tb_inpdt_seq_ctrl.sv
// Directed bench for inpdt_seq_ctrl with a 1-cycle buffer model and a
// result scoreboard.
module tb_inpdt_seq_ctrl;

    logic        iClk = 1'b0;
    logic        iRstn;
    logic        iStart;
    logic [4:0]  iNumChunk;
    logic        iAbort;
    logic [20:0] iInpdtResult;
    logic        iReady;
    logic [3:0]  oAddr;
    logic        oRdEn;
    logic        oInpdtEn;
    logic        oBusy;
    logic [24:0] oAcc;
    logic        oValid;
    logic        oErr;

    logic [20:0] mem [16];
    logic [20:0] rd_data;
    int          sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    inpdt_seq_ctrl dut (
        .iClk         (iClk),
        .iRstn        (iRstn),
        .iStart       (iStart),
        .iNumChunk    (iNumChunk),
        .iAbort       (iAbort),
        .iInpdtResult (iInpdtResult),
        .iReady       (iReady),
        .oAddr        (oAddr),
        .oRdEn        (oRdEn),
        .oInpdtEn     (oInpdtEn),
        .oBusy        (oBusy),
        .oAcc         (oAcc),
        .oValid       (oValid),
        .oErr         (oErr)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) begin
        if (oRdEn) rd_data <= mem[oAddr];
    end
    assign iInpdtResult = rd_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int a, input int b, input int c, input int d,
                        input bit same, input int v);
        for (int i = 0; i < 16; i++) mem[i] = 21'(same ? v : 0);
        if (!same) begin
            mem[0] = 21'(a);
            mem[1] = 21'(b);
            mem[2] = 21'(c);
            mem[3] = 21'(d);
        end
    endtask

    task automatic run_job(input int n, input string tag);
        int  s;
        int  k;
        int  nrd;
        int  first_rd;
        int  last_rd;
        bit  addr_ok;
        bit  got;
        s = 0;
        for (int i = 0; i < n; i++) s += int'(mem[i]);
        sb.push_back(s);
        iNumChunk = 5'(n);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk({tag, "_busy"}, 32'(oBusy), 1);
        k = 0; nrd = 0; first_rd = -1; last_rd = -1;
        addr_ok = 1'b1; got = 1'b0;
        while (k < 60 && !got) begin
            @(negedge iClk);
            k++;
            if (oRdEn) begin
                if (int'(oAddr) != nrd) addr_ok = 1'b0;
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                nrd++;
            end
            if (oValid) got = 1'b1;
        end
        chk({tag, "_valid_edge"}, got ? k : -1, n + 2);
        chk({tag, "_rd_count"}, nrd, n);
        chk({tag, "_addr_seq"}, 32'(addr_ok), 1);
        chk({tag, "_first_rd"}, first_rd, 1);
        chk({tag, "_last_rd"}, last_rd, n);
    endtask

    task automatic accept(input string tag);
        int e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        e = (sb.size() != 0) ? sb.pop_front() : -1;
        chk({tag, "_acc"}, 32'(oAcc), e);
        chk({tag, "_valid"}, 32'(oValid), 1);
        iReady = 1'b1;
        @(negedge iClk);
        iReady = 1'b0;
        chk({tag, "_valid_drop"}, 32'(oValid), 0);
        chk({tag, "_idle"}, 32'(oBusy), 0);
        chk({tag, "_acc_hold"}, 32'(oAcc), e);
    endtask

    initial begin
        logic [24:0] held;
        bit          seen_valid;
        iRstn = 1'b0; iStart = 1'b0; iNumChunk = '0;
        iAbort = 1'b0; iReady = 1'b0; rd_data = '0;
        fill(0, 0, 0, 0, 1'b1, 0);
        #12;
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_outs", {oAddr, oRdEn, oInpdtEn, oValid, oErr}, 0);
        chk("rst_acc", 32'(oAcc), 0);
        @(negedge iClk);
        iRstn = 1'b1;
        @(negedge iClk);

        fill(0, 0, 0, 0, 1'b1, 16);
        run_job(1, "n1");
        accept("n1");

        fill(100, 200, 300, 400, 1'b0, 0);
        run_job(4, "n4");
        accept("n4");

        fill(0, 0, 0, 0, 1'b1, 1040400);
        run_job(16, "n16");
        accept("n16");

        // Backpressure in DONE with stray start pulses
        fill(7, 9, 11, 13, 1'b0, 0);
        run_job(3, "bp");
        held = oAcc;
        for (int i = 0; i < 5; i++) begin
            iStart = 1'b1; iNumChunk = 5'd2;
            @(negedge iClk);
            iStart = 1'b0;
            chk("bp_valid_hold", 32'(oValid), 1);
            chk("bp_acc_hold", 32'(oAcc), 32'(held));
            chk("bp_no_err", 32'(oErr), 0);
        end
        accept("bp");
        fill(5, 6, 0, 0, 1'b0, 0);
        run_job(2, "fresh");
        accept("fresh");

        // Invalid chunk counts
        iNumChunk = 5'd0; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("inv0_err", 32'(oErr), 1);
        chk("inv0_busy", 32'(oBusy), 0);
        @(negedge iClk);
        chk("inv0_err_pulse", 32'(oErr), 0);
        chk("inv0_rd", 32'(oRdEn), 0);
        iNumChunk = 5'd17; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("inv17_err", 32'(oErr), 1);
        chk("inv17_busy", 32'(oBusy), 0);
        @(negedge iClk);
        chk("inv17_err_pulse", 32'(oErr), 0);
        chk("inv17_rd", 32'(oRdEn), 0);

        // Abort in IDLE blocks a simultaneous start
        iNumChunk = 5'd2; iStart = 1'b1; iAbort = 1'b1;
        @(negedge iClk);
        iStart = 1'b0; iAbort = 1'b0;
        chk("idle_abort_busy", 32'(oBusy), 0);

        // Abort mid-job
        fill(0, 0, 0, 0, 1'b1, 50);
        iNumChunk = 5'd8; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (3) @(negedge iClk);
        chk("abort_pre_acc", 32'(oAcc), 50);
        iAbort = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0;
        chk("abort_busy", 32'(oBusy), 0);
        chk("abort_acc", 32'(oAcc), 0);
        chk("abort_rd_en", {oRdEn, oInpdtEn, oValid}, 0);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge iClk);
            if (oValid || oBusy) seen_valid = 1'b1;
        end
        chk("abort_quiet", 32'(seen_valid), 0);
        chk("abort_acc_stays", 32'(oAcc), 0);

        // Reset mid-job takes effect before the next clock edge
        iNumChunk = 5'd8; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (4) @(negedge iClk);
        chk("rstmid_busy_pre", 32'(oBusy), 1);
        #2 iRstn = 1'b0;
        #1;
        chk("rstmid_busy", 32'(oBusy), 0);
        chk("rstmid_outs", {oAddr, oRdEn, oInpdtEn, oValid, oErr}, 0);
        chk("rstmid_acc", 32'(oAcc), 0);
        @(negedge iClk);
        iRstn = 1'b1;
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge iClk);
            if (oValid || oBusy) seen_valid = 1'b1;
        end
        chk("rstmid_quiet", 32'(seen_valid), 0);

        fill(1, 2, 3, 4, 1'b0, 0);
        run_job(4, "post_rst");
        accept("post_rst");
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
